// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline MEM stage. Passes ALU results straight to WB,
// issues aligned load/store requests to data memory, extracts and extends
// load data, and reports misaligned/illegal accesses and bus timeouts.
module mem_access_unit #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluresult,
    input  logic [31:0] ex_rs2data,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        flush,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        mem_fault,
    output logic        bus_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // Latched operation fields, valid while in ACCESS
    logic [31:0] op_addr;
    logic [31:0] op_rs2;
    logic [2:0]  op_funct3;
    logic [4:0]  op_rd;
    logic        op_regwrite;
    logic        op_store;

    logic        accept;
    logic        ex_store;
    logic        ex_mem;
    logic        ex_bad;
    logic [1:0]  ex_off;
    logic [1:0]  op_off;
    logic        in_access;

    logic [31:0] load_data;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;

    logic        wb_valid_d;
    logic [31:0] wb_data_d;
    logic [4:0]  wb_rd_d;
    logic        wb_regwrite_d;
    logic        mem_fault_d;
    logic        bus_err_d;

    assign in_access = (state_q == ACCESS);
    assign ex_store  = ex_memwrite;
    assign ex_mem    = ex_memread | ex_memwrite;
    assign ex_off    = ex_aluresult[1:0];
    assign op_off    = op_addr[1:0];

    // Legality check of the incoming memory op: size code and alignment
    always_comb begin
        ex_bad = 1'b0;
        case (ex_funct3)
            3'b000:  ex_bad = 1'b0;
            3'b001:  ex_bad = ex_off[0];
            3'b010:  ex_bad = (ex_off != 2'b00);
            3'b100:  ex_bad = ex_store;
            3'b101:  ex_bad = ex_store | ex_off[0];
            default: ex_bad = 1'b1;
        endcase
    end

    // Store byte enables and replicated write data from latched fields
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = op_rs2;
        if (op_store) begin
            case (op_funct3)
                3'b000: begin
                    st_be    = 4'b0001 << op_off;
                    st_wdata = {4{op_rs2[7:0]}};
                end
                3'b001: begin
                    st_be    = op_off[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{op_rs2[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = op_rs2;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        logic [7:0]  bsel;
        logic [15:0] hsel;
        case (op_off)
            2'd0:    bsel = dmem_rdata[7:0];
            2'd1:    bsel = dmem_rdata[15:8];
            2'd2:    bsel = dmem_rdata[23:16];
            default: bsel = dmem_rdata[31:24];
        endcase
        hsel = op_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_funct3)
            3'b000:  load_data = {{24{bsel[7]}}, bsel};
            3'b100:  load_data = {24'b0, bsel};
            3'b001:  load_data = {{16{hsel[15]}}, hsel};
            3'b101:  load_data = {16'b0, hsel};
            default: load_data = dmem_rdata;
        endcase
    end

    // Memory request outputs are driven only in ACCESS so reset clears them at once
    always_comb begin
        mem_stall  = in_access;
        dmem_req   = in_access;
        dmem_we    = in_access & op_store;
        dmem_addr  = in_access ? {op_addr[31:2], 2'b00} : '0;
        dmem_wdata = (in_access && op_store) ? st_wdata : '0;
        dmem_be    = in_access ? st_be : '0;
    end

    // Next-state, wait counter and next WB result
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        accept        = 1'b0;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data;
        wb_rd_d       = wb_rd;
        wb_regwrite_d = 1'b0;
        mem_fault_d   = 1'b0;
        bus_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (!ex_mem) begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = ex_aluresult;
                        wb_rd_d       = ex_rd;
                        wb_regwrite_d = ex_regwrite;
                    end else if (ex_bad) begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = ex_aluresult;
                        wb_rd_d       = ex_rd;
                        mem_fault_d   = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Completion takes priority over a timeout on the same cycle
                if (dmem_ready) begin
                    state_d       = IDLE;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = op_rd;
                    wb_regwrite_d = op_store ? 1'b0 : op_regwrite;
                    wb_data_d     = op_store ? op_addr : load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = op_rd;
                    wb_data_d  = op_addr;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered WB outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            mem_fault   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_valid    <= wb_valid_d;
            wb_data     <= wb_data_d;
            wb_rd       <= wb_rd_d;
            wb_regwrite <= wb_regwrite_d;
            mem_fault   <= mem_fault_d;
            bus_err     <= bus_err_d;
        end
    end

    // Capture the accepted memory operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_addr     <= '0;
            op_rs2      <= '0;
            op_funct3   <= '0;
            op_rd       <= '0;
            op_regwrite <= 1'b0;
            op_store    <= 1'b0;
        end else if (accept) begin
            op_addr     <= ex_aluresult;
            op_rs2      <= ex_rs2data;
            op_funct3   <= ex_funct3;
            op_rd       <= ex_rd;
            op_regwrite <= ex_regwrite;
            op_store    <= ex_store;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with WAIT_MAX = 4.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_aluresult;
    logic [31:0] ex_rs2data;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        flush;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        mem_fault;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_aluresult(ex_aluresult), .ex_rs2data(ex_rs2data),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .flush(flush),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .mem_fault(mem_fault), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [31:0] a, input logic [31:0] d,
                            input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [4:0] rd, input logic rw);
        ex_valid = v; ex_aluresult = a; ex_rs2data = d; ex_memread = rd_en;
        ex_memwrite = wr_en; ex_funct3 = f3; ex_rd = rd; ex_regwrite = rw;
    endtask

    task automatic idle_inputs();
        drive_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        idle_inputs();
        #2;
        checks++;
        if ({mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data,
             wb_rd, wb_regwrite, mem_fault, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero output (wb_valid=%b dmem_req=%b wb_data=%h) expected all 0",
                     wb_valid, dmem_req, wb_data);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        drive_op(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        step();
        checks++;
        if ({wb_valid, wb_data, wb_rd, wb_regwrite, mem_stall} !== {1'b1, 32'h1234, 5'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL alu_wb: got v=%b d=%h rd=%0d rw=%b st=%b expected 1 00001234 5 1 0",
                     wb_valid, wb_data, wb_rd, wb_regwrite, mem_stall);
        end
        idle_inputs();
        step();
        checks++;
        if ({wb_valid, wb_regwrite} !== 2'b00) begin
            errors++;
            $display("FAIL alu_deassert: got v=%b rw=%b expected 0 0", wb_valid, wb_regwrite);
        end
    endtask

    task automatic test_flush();
        drive_op(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1);
        flush = 1'b1;
        step();
        checks++;
        if ({wb_valid, dmem_req, mem_stall} !== 3'b000) begin
            errors++;
            $display("FAIL flush: got v=%b req=%b st=%b expected 0 0 0", wb_valid, dmem_req, mem_stall);
        end
        idle_inputs();
    endtask

    task automatic test_lb_wait();
        int stall_cycles = 0;
        drive_op(1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1);
        step();
        idle_inputs();
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 32'h100, 4'b1111}) begin
            errors++;
            $display("FAIL lb_req: got req=%b we=%b addr=%h be=%b expected 1 0 00000100 1111",
                     dmem_req, dmem_we, dmem_addr, dmem_be);
        end
        for (int i = 0; i < 2; i++) begin
            if (mem_stall) stall_cycles++;
            step();
        end
        dmem_ready = 1'b1; dmem_rdata = 32'h80FFFFFF;
        if (mem_stall) stall_cycles++;
        step();
        dmem_ready = 1'b0;
        checks++;
        if (stall_cycles != 3 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL lb_stall: got %0d stall cycles (now %b) expected 3 (now 0)", stall_cycles, mem_stall);
        end
        checks++;
        if ({wb_valid, wb_data, wb_rd, wb_regwrite} !== {1'b1, 32'hFFFFFF80, 5'd7, 1'b1}) begin
            errors++;
            $display("FAIL lb_wb: got v=%b d=%h rd=%0d rw=%b expected 1 ffffff80 7 1",
                     wb_valid, wb_data, wb_rd, wb_regwrite);
        end
    endtask

    task automatic test_lhu();
        drive_op(1'b1, 32'h2, 32'h0, 1'b1, 1'b0, 3'b101, 5'd9, 1'b1);
        step();
        idle_inputs();
        dmem_ready = 1'b1; dmem_rdata = 32'h80011234;
        step();
        dmem_ready = 1'b0;
        checks++;
        if ({wb_valid, wb_data} !== {1'b1, 32'h00008001}) begin
            errors++;
            $display("FAIL lhu_data: got v=%b d=%h expected 1 00008001", wb_valid, wb_data);
        end
    endtask

    task automatic test_sh();
        drive_op(1'b1, 32'h202, 32'hABCD1234, 1'b0, 1'b1, 3'b001, 5'd4, 1'b1);
        step();
        idle_inputs();
        dmem_ready = 1'b1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
            {1'b1, 1'b1, 32'h200, 4'b1100, 32'h12341234}) begin
            errors++;
            $display("FAIL sh_req: got req=%b we=%b addr=%h be=%b wd=%h expected 1 1 00000200 1100 12341234",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        step();
        dmem_ready = 1'b0;
        checks++;
        if ({wb_valid, wb_regwrite, wb_data} !== {1'b1, 1'b0, 32'h202}) begin
            errors++;
            $display("FAIL sh_wb: got v=%b rw=%b d=%h expected 1 0 00000202", wb_valid, wb_regwrite, wb_data);
        end
    endtask

    task automatic test_sb_priority();
        // memread and memwrite both high: treated as a store
        drive_op(1'b1, 32'h13, 32'h00000055, 1'b1, 1'b1, 3'b000, 5'd2, 1'b1);
        step();
        idle_inputs();
        checks++;
        if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 32'h10, 4'b1000, 32'h55555555}) begin
            errors++;
            $display("FAIL sb_req: got we=%b addr=%h be=%b wd=%h expected 1 00000010 1000 55555555",
                     dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        checks++;
        if ({wb_valid, wb_regwrite} !== 2'b10) begin
            errors++;
            $display("FAIL sb_wb: got v=%b rw=%b expected 1 0", wb_valid, wb_regwrite);
        end
    endtask

    task automatic test_fault();
        drive_op(1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 3'b010, 5'd6, 1'b1);
        step();
        checks++;
        if ({dmem_req, mem_fault, wb_valid, wb_regwrite, mem_stall, wb_data} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h101}) begin
            errors++;
            $display("FAIL lw_misaligned: got req=%b flt=%b v=%b rw=%b st=%b d=%h expected 0 1 1 0 0 00000101",
                     dmem_req, mem_fault, wb_valid, wb_regwrite, mem_stall, wb_data);
        end
        // Store with an unsigned size code is illegal
        drive_op(1'b1, 32'h40, 32'h0, 1'b0, 1'b1, 3'b100, 5'd6, 1'b0);
        step();
        checks++;
        if ({dmem_req, mem_fault, wb_valid} !== 3'b011) begin
            errors++;
            $display("FAIL store_bu_illegal: got req=%b flt=%b v=%b expected 0 1 1", dmem_req, mem_fault, wb_valid);
        end
        idle_inputs();
        step();
        checks++;
        if ({mem_fault, wb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fault_pulse: got flt=%b v=%b expected 0 0", mem_fault, wb_valid);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        drive_op(1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1);
        step();
        idle_inputs();
        while (dmem_req && req_cycles < 10) begin
            req_cycles++;
            step();
        end
        checks++;
        if (req_cycles != 4) begin
            errors++;
            $display("FAIL timeout_len: got %0d request cycles expected 4", req_cycles);
        end
        checks++;
        if ({bus_err, wb_valid, wb_regwrite, mem_stall, dmem_req} !== 5'b11000) begin
            errors++;
            $display("FAIL timeout_wb: got be=%b v=%b rw=%b st=%b req=%b expected 1 1 0 0 0",
                     bus_err, wb_valid, wb_regwrite, mem_stall, dmem_req);
        end
        step();
        checks++;
        if ({bus_err, wb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL buserr_pulse: got be=%b v=%b expected 0 0", bus_err, wb_valid);
        end
    endtask

    task automatic test_ready_at_limit();
        drive_op(1'b1, 32'h500, 32'h0, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1);
        step();
        idle_inputs();
        step(); step(); step();
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_ready = 1'b0;
        checks++;
        if ({wb_valid, bus_err, wb_regwrite, wb_data} !== {1'b1, 1'b0, 1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL ready_at_limit: got v=%b be=%b rw=%b d=%h expected 1 0 1 cafef00d",
                     wb_valid, bus_err, wb_regwrite, wb_data);
        end
    endtask

    task automatic test_reset_mid_access();
        drive_op(1'b1, 32'h600, 32'h0, 1'b1, 1'b0, 3'b010, 5'd11, 1'b1);
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        dmem_ready = 1'b1;
        #1;
        checks++;
        if ({dmem_req, mem_stall, wb_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_access: got req=%b st=%b v=%b expected 0 0 0", dmem_req, mem_stall, wb_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        dmem_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_wb: got v=%b expected 0", wb_valid);
        end
        drive_op(1'b1, 32'hBEEF, 32'h0, 1'b0, 1'b0, 3'b000, 5'd12, 1'b1);
        step();
        idle_inputs();
        checks++;
        if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'hBEEF, 5'd12}) begin
            errors++;
            $display("FAIL post_reset_op: got v=%b d=%h rd=%0d expected 1 0000beef 12", wb_valid, wb_data, wb_rd);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_flush();
        test_lb_wait();
        test_lhu();
        test_sh();
        test_sb_priority();
        test_fault();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
